pipelined_cla_adder: RTL and testbench

- Parametrised, pipelined carry-lookahead adder/subtractor. Successor to the 4-bit CLA and ripple-carry blocks.
- Operand width is split into 4-bit lookahead groups. Each pipeline stage resolves one or more groups; carry between stages is registered.
- Elastic valid/ready on both sides. Sits in datapaths that need one add per cycle at a clock rate too fast for a full-width carry chain.

---
 rtl/adder_pkg.sv | 19 +
 rtl/pipelined_cla_adder_cla_group.sv | 62 ++++++
 rtl/pipelined_cla_adder.sv | 135 +++++++++++++
 tb/tb_pipelined_cla_adder.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// Shared constants, helpers and stage payload type
// for the pipelined carry-lookahead adder.
package adder_pkg;

    localparam int BLOCK_DEF = 4;

    // Per-stage bookkeeping that travels alongside the operand/sum words.
    typedef struct packed {
        logic carry;
        logic a_msb;
        logic b_msb;
    } stage_meta_t;

    function automatic int calc_stages(input int width, input int block,
                                       input int gps);
        return width / (block * gps);
    endfunction

endpackage

// File: rtl/pipelined_cla_adder_cla_group.sv
// One BLOCK-bit carry-lookahead group: every internal carry is
// a flat sum of generate/propagate products.
module cla_group
    import adder_pkg::*;
#(
    parameter int BLOCK = BLOCK_DEF
) (
    input  logic [BLOCK-1:0] a,
    input  logic [BLOCK-1:0] b,
    input  logic             cin,
    output logic [BLOCK-1:0] sum,
    output logic             gg,
    output logic             gp,
    output logic             cout
);

    logic [BLOCK-1:0] g;
    logic [BLOCK-1:0] p;
    logic [BLOCK:0]   c;
    logic             t;
    logic             gt;

    assign g = a & b;
    assign p = a ^ b;

    always_comb begin
        c    = '0;
        t    = 1'b0;
        c[0] = cin;
        for (int i = 1; i <= BLOCK; i++) begin
            c[i] = cin;
            for (int j = 0; j < i; j++) begin
                c[i] = c[i] & p[j];
            end
            for (int j = 0; j < i; j++) begin
                t = g[j];
                for (int m = j + 1; m < i; m++) begin
                    t = t & p[m];
                end
                c[i] = c[i] | t;
            end
        end
    end

    always_comb begin
        gt = 1'b0;
        for (int j = 0; j < BLOCK; j++) begin
            logic term;
            term = g[j];
            for (int m = j + 1; m < BLOCK; m++) begin
                term = term & p[m];
            end
            gt = gt | term;
        end
    end

    assign sum  = p ^ c[BLOCK-1:0];
    assign gg   = gt;
    assign gp   = &p;
    assign cout = c[BLOCK];

endmodule

// File: rtl/pipelined_cla_adder.sv
// Elastic pipelined CLA adder/subtractor: one slice of
// GROUPS_PER_STAGE lookahead groups is resolved per stage.
module pipelined_cla_adder
    import adder_pkg::*;
#(
    parameter int WIDTH            = 16,
    parameter int BLOCK            = BLOCK_DEF,
    parameter int GROUPS_PER_STAGE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int STAGES = calc_stages(WIDTH, BLOCK, GROUPS_PER_STAGE);
    localparam int SW     = BLOCK * GROUPS_PER_STAGE;

    // x holds finished sum slices below the current slice and raw a above.
    logic             v_q   [STAGES];
    logic [WIDTH-1:0] x_q   [STAGES];
    logic [WIDTH-1:0] y_q   [STAGES];
    stage_meta_t      m_q   [STAGES];

    logic             v_src [STAGES];
    logic [WIDTH-1:0] x_src [STAGES];
    logic [WIDTH-1:0] y_src [STAGES];
    stage_meta_t      m_src [STAGES];

    logic [WIDTH-1:0] x_nxt [STAGES];
    stage_meta_t      m_nxt [STAGES];
    logic             ld    [STAGES];

    logic [WIDTH-1:0] b_eff;

    assign b_eff = sub ? ~b : b;

    always_comb begin
        ld[STAGES-1] = !v_q[STAGES-1] || out_ready;
        for (int k = STAGES - 2; k >= 0; k--) begin
            ld[k] = !v_q[k] || ld[k+1];
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic [SW-1:0]               s_st;
        logic [GROUPS_PER_STAGE-1:0] gg;
        logic [GROUPS_PER_STAGE-1:0] gp;
        logic                        ci [GROUPS_PER_STAGE+1];
        logic [WIDTH-1:0]            xn;
        stage_meta_t                 mn;

        if (k == 0) begin : g_head
            assign v_src[0] = in_valid;
            assign x_src[0] = a;
            assign y_src[0] = b_eff;
            assign m_src[0] = '{carry: sub | cin,
                                a_msb: a[WIDTH-1],
                                b_msb: b_eff[WIDTH-1]};
        end else begin : g_body
            assign v_src[k] = v_q[k-1];
            assign x_src[k] = x_q[k-1];
            assign y_src[k] = y_q[k-1];
            assign m_src[k] = m_q[k-1];
        end

        assign ci[0] = m_src[k].carry;

        for (genvar g = 0; g < GROUPS_PER_STAGE; g++) begin : g_grp
            cla_group #(
                .BLOCK(BLOCK)
            ) u_grp (
                .a   (x_src[k][k*SW + g*BLOCK +: BLOCK]),
                .b   (y_src[k][k*SW + g*BLOCK +: BLOCK]),
                .cin (ci[g]),
                .sum (s_st[g*BLOCK +: BLOCK]),
                .gg  (gg[g]),
                .gp  (gp[g]),
                .cout(ci[g+1])
            );
        end

        // Slice carry-out comes from the group G/P terms, not the ripple.
        always_comb begin
            mn = m_src[k];
            for (int g = 0; g < GROUPS_PER_STAGE; g++) begin
                mn.carry = gg[g] | (gp[g] & mn.carry);
            end
            xn = x_src[k];
            xn[k*SW +: SW] = s_st;
        end

        assign x_nxt[k] = xn;
        assign m_nxt[k] = mn;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < STAGES; k++) begin
                v_q[k] <= 1'b0;
                x_q[k] <= '0;
                y_q[k] <= '0;
                m_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (ld[k]) begin
                    v_q[k] <= v_src[k];
                end
                if (ld[k] && v_src[k]) begin
                    x_q[k] <= x_nxt[k];
                    y_q[k] <= y_src[k];
                    m_q[k] <= m_nxt[k];
                end
            end
        end
    end

    assign in_ready  = ld[0];
    assign out_valid = v_q[STAGES-1];
    assign sum       = x_q[STAGES-1];
    assign cout      = m_q[STAGES-1].carry;
    assign ovf       = (m_q[STAGES-1].a_msb == m_q[STAGES-1].b_msb) &&
                       (x_q[STAGES-1][WIDTH-1] != m_q[STAGES-1].a_msb);

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Directed and streaming checks for pipelined_cla_adder
// at WIDTH=16 plus a WIDTH=32 stage-count sweep.
module tb_pipelined_cla_adder;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        cin;
    logic        sub;
    logic        out_ready;
    logic [31:0] a;
    logic [31:0] b;

    logic        ir16, ov16, c16, o16;
    logic [15:0] s16;
    logic        ir1, ov1, c1, o1;
    logic [31:0] s1;
    logic        ir2, ov2, c2, o2;
    logic [31:0] s2;
    logic        ir8, ov8, c8, o8;
    logic [31:0] s8;

    int npass  = 0;
    int ntotal = 0;

    always #5 clk = ~clk;

    pipelined_cla_adder #(.WIDTH(16), .BLOCK(4), .GROUPS_PER_STAGE(1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir16),
        .a(a[15:0]), .b(b[15:0]), .cin(cin), .sub(sub),
        .out_valid(ov16), .out_ready(out_ready),
        .sum(s16), .cout(c16), .ovf(o16)
    );

    pipelined_cla_adder #(.WIDTH(32), .BLOCK(4), .GROUPS_PER_STAGE(1)) dut32_g1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir1),
        .a(a), .b(b), .cin(cin), .sub(sub),
        .out_valid(ov1), .out_ready(out_ready),
        .sum(s1), .cout(c1), .ovf(o1)
    );

    pipelined_cla_adder #(.WIDTH(32), .BLOCK(4), .GROUPS_PER_STAGE(2)) dut32_g2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir2),
        .a(a), .b(b), .cin(cin), .sub(sub),
        .out_valid(ov2), .out_ready(out_ready),
        .sum(s2), .cout(c2), .ovf(o2)
    );

    pipelined_cla_adder #(.WIDTH(32), .BLOCK(4), .GROUPS_PER_STAGE(8)) dut32_g8 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir8),
        .a(a), .b(b), .cin(cin), .sub(sub),
        .out_valid(ov8), .out_ready(out_ready),
        .sum(s8), .cout(c8), .ovf(o8)
    );

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        ci;
        logic        sb;
        logic [15:0] s;
        logic        c;
        logic        o;
    } vec_t;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Reference built from signed integer arithmetic: {cout, ovf, sum}.
    function automatic logic [17:0] model(input logic [15:0] x,
                                          input logic [15:0] y,
                                          input logic c, input logic s);
        int          sx, sy, r;
        logic        co;
        logic [15:0] sm;
        sx = int'($signed(x));
        sy = int'($signed(y));
        if (s) begin
            r  = sx - sy;
            co = (x >= y);
            sm = x - y;
        end else begin
            r  = sx + sy + int'(c);
            {co, sm} = {1'b0, x} + {1'b0, y} + {16'b0, c};
        end
        return {co, (r > 32767) || (r < -32768), sm};
    endfunction

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        tick();
        tick();
        ntotal++;
        if (ov16 !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", ov16);
        else npass++;
        ntotal++;
        if (s16 !== 16'h0) $display("FAIL reset_sum: got %h want 0000", s16);
        else npass++;
        ntotal++;
        if ({c16, o16} !== 2'b00) $display("FAIL reset_cout_ovf: got %b want 00", {c16, o16});
        else npass++;
        rst = 1'b0;
        #1;
        ntotal++;
        if (ir16 !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", ir16);
        else npass++;
    endtask

    task automatic test_directed();
        vec_t tbl [7];
        int   lat;
        tbl[0] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
        tbl[1] = '{16'h7FFF, 16'h0000, 1'b1, 1'b0, 16'h8000, 1'b0, 1'b1};
        tbl[2] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
        tbl[3] = '{16'h0003, 16'h0005, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0};
        tbl[4] = '{16'h0005, 16'h0003, 1'b1, 1'b1, 16'h0002, 1'b1, 1'b0};
        tbl[5] = '{16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0};
        tbl[6] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
        out_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            a = {16'h0, tbl[i].a};
            b = {16'h0, tbl[i].b};
            cin = tbl[i].ci;
            sub = tbl[i].sb;
            in_valid = 1'b1;
            tick();
            in_valid = 1'b0;
            lat = 1;
            while (ov16 !== 1'b1 && lat < 20) begin
                tick();
                lat++;
            end
            ntotal++;
            if (lat != 4) $display("FAIL dir%0d_latency: got %0d want 4", i, lat);
            else npass++;
            ntotal++;
            if (s16 !== tbl[i].s) $display("FAIL dir%0d_sum: got %h want %h", i, s16, tbl[i].s);
            else npass++;
            ntotal++;
            if (c16 !== tbl[i].c) $display("FAIL dir%0d_cout: got %b want %b", i, c16, tbl[i].c);
            else npass++;
            ntotal++;
            if (o16 !== tbl[i].o) $display("FAIL dir%0d_ovf: got %b want %b", i, o16, tbl[i].o);
            else npass++;
            tick();
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] qa [20];
        logic [15:0] qb [20];
        logic        qc [20];
        logic        qs [20];
        logic [17:0] expq [$];
        logic [17:0] e, prev_out;
        logic        prev_hold, acc, emt, exp_ir;
        logic [4:0]  pat;
        int          sent, got, inflight, cyc;
        pat = 5'b00011;
        for (int i = 0; i < 20; i++) begin
            qa[i] = 16'($urandom);
            qb[i] = 16'($urandom);
            qc[i] = 1'($urandom);
            qs[i] = (i % 3 == 1);
        end
        qa[5] = 16'h7FFF; qb[5] = 16'h0001; qs[5] = 1'b0; qc[5] = 1'b0;
        sent = 0; got = 0; inflight = 0; cyc = 0;
        prev_hold = 1'b0; prev_out = '0;
        while (got < 20 && cyc < 300) begin
            out_ready = pat[cyc % 5];
            if (sent < 20) begin
                in_valid = 1'b1;
                a = {16'h0, qa[sent]};
                b = {16'h0, qb[sent]};
                cin = qc[sent];
                sub = qs[sent];
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (prev_hold) begin
                ntotal++;
                if (ov16 !== 1'b1 || {c16, o16, s16} !== prev_out)
                    $display("FAIL stall_stable: got %b/%h want 1/%h", ov16, {c16, o16, s16}, prev_out);
                else npass++;
            end
            exp_ir = !(inflight == 4 && !out_ready);
            ntotal++;
            if (ir16 !== exp_ir)
                $display("FAIL stream_in_ready: cyc %0d got %b want %b", cyc, ir16, exp_ir);
            else npass++;
            acc = in_valid && ir16;
            emt = ov16 && out_ready;
            if (emt) begin
                ntotal++;
                if (expq.size() == 0) begin
                    $display("FAIL stream_extra: got %h want none", {c16, o16, s16});
                end else begin
                    e = expq.pop_front();
                    if ({c16, o16, s16} !== e)
                        $display("FAIL stream_result%0d: got %h want %h", got, {c16, o16, s16}, e);
                    else npass++;
                end
                got++;
            end
            if (acc) begin
                expq.push_back(model(qa[sent], qb[sent], qc[sent], qs[sent]));
                sent++;
            end
            inflight = inflight + int'(acc) - int'(emt);
            prev_hold = ov16 && !out_ready;
            prev_out = {c16, o16, s16};
            tick();
            cyc++;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        ntotal++;
        if (got != 20 || sent != 20)
            $display("FAIL stream_count: got %0d/%0d want 20/20", got, sent);
        else npass++;
        ntotal++;
        if (expq.size() != 0) $display("FAIL stream_left: got %0d want 0", expq.size());
        else npass++;
        tick();
    endtask

    task automatic test_reset_midflight();
        logic [17:0] first;
        int          seen, lat_seen;
        out_ready = 1'b1;
        in_valid = 1'b1;
        cin = 1'b0; sub = 1'b0;
        for (int i = 0; i < 3; i++) begin
            a = 32'h1111 * (i + 1);
            b = 32'h0101;
            tick();
        end
        in_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        ntotal++;
        if (ov16 !== 1'b0) $display("FAIL rstmid_out_valid: got %b want 0", ov16);
        else npass++;
        ntotal++;
        if (s16 !== 16'h0) $display("FAIL rstmid_sum: got %h want 0000", s16);
        else npass++;
        a = 32'h00FF; b = 32'h0F01;
        in_valid = 1'b1;
        #1;
        ntotal++;
        if (ir16 !== 1'b1) $display("FAIL rstmid_in_ready: got %b want 1", ir16);
        else npass++;
        tick();
        in_valid = 1'b0;
        seen = 0; lat_seen = 0; first = '0;
        for (int t = 1; t <= 10; t++) begin
            if (ov16 === 1'b1) begin
                if (seen == 0) begin
                    lat_seen = t;
                    first = {c16, o16, s16};
                end
                seen++;
            end
            tick();
        end
        ntotal++;
        if (seen != 1) $display("FAIL rstmid_emits: got %0d want 1", seen);
        else npass++;
        ntotal++;
        if (lat_seen != 4) $display("FAIL rstmid_latency: got %0d want 4", lat_seen);
        else npass++;
        ntotal++;
        if (first !== {2'b00, 16'h1000}) $display("FAIL rstmid_result: got %h want %h", first, {2'b00, 16'h1000});
        else npass++;
    endtask

    task automatic test_param_sweep();
        int          l1, l2, l8;
        logic [33:0] r1, r2, r8;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        tick();
        rst = 1'b0;
        a = 32'hFFFF_FFFF; b = 32'h0000_0001; cin = 1'b0; sub = 1'b0;
        in_valid = 1'b1;
        #1;
        ntotal++;
        if ({ir1, ir2, ir8} !== 3'b111) $display("FAIL sweep_in_ready: got %b want 111", {ir1, ir2, ir8});
        else npass++;
        tick();
        in_valid = 1'b0;
        l1 = 0; l2 = 0; l8 = 0;
        r1 = '0; r2 = '0; r8 = '0;
        for (int t = 1; t <= 12; t++) begin
            if (ov1 === 1'b1 && l1 == 0) begin l1 = t; r1 = {c1, o1, s1}; end
            if (ov2 === 1'b1 && l2 == 0) begin l2 = t; r2 = {c2, o2, s2}; end
            if (ov8 === 1'b1 && l8 == 0) begin l8 = t; r8 = {c8, o8, s8}; end
            tick();
        end
        ntotal++;
        if (l1 != 8) $display("FAIL sweep_g1_latency: got %0d want 8", l1);
        else npass++;
        ntotal++;
        if (l2 != 4) $display("FAIL sweep_g2_latency: got %0d want 4", l2);
        else npass++;
        ntotal++;
        if (l8 != 1) $display("FAIL sweep_g8_latency: got %0d want 1", l8);
        else npass++;
        ntotal++;
        if (r1 !== 34'h2_0000_0000) $display("FAIL sweep_g1_result: got %h want 200000000", r1);
        else npass++;
        ntotal++;
        if (r2 !== 34'h2_0000_0000) $display("FAIL sweep_g2_result: got %h want 200000000", r2);
        else npass++;
        ntotal++;
        if (r8 !== 34'h2_0000_0000) $display("FAIL sweep_g8_result: got %h want 200000000", r8);
        else npass++;
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_reset_midflight();
        test_param_sweep();
        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

endmodule
